// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcode/funct fields,
// ALU control codes, ALU operand-B selects and the decoded-instruction record.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_BRANCH = 3'd4,
      ST_ERR    = 3'd5
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRL  = 6'b000010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;

   localparam logic [1:0] SRCB_RT   = 2'd0;
   localparam logic [1:0] SRCB_SEXT = 2'd1;
   localparam logic [1:0] SRCB_ZEXT = 2'd2;

   typedef enum logic [1:0] {
      CLS_RTYPE   = 2'd0,
      CLS_IMM     = 2'd1,
      CLS_BEQ     = 2'd2,
      CLS_ILLEGAL = 2'd3
   } cls_e;

   typedef struct packed {
      cls_e       cls;
      logic [3:0] alu_ctrl;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       legal;
   } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
// Strobes are single-cycle level signals sampled on the rising clock edge; there is no backpressure.
interface multicycle_ctrl_if;
   logic [5:0] op_i;
   logic [5:0] funct_i;
   logic       imem_ack_i;
   logic       zero_i;
   logic       imem_req_o;
   logic       ir_we_o;
   logic       pc_we_o;
   logic       pc_src_o;
   logic       alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [3:0] alu_ctrl_o;
   logic       reg_we_o;
   logic       reg_dst_o;
   logic       illegal_o;
   logic [2:0] state_o;

   modport master (
      output op_i, funct_i, imem_ack_i, zero_i,
      input  imem_req_o, ir_we_o, pc_we_o, pc_src_o, alu_src_a_o, alu_src_b_o,
             alu_ctrl_o, reg_we_o, reg_dst_o, illegal_o, state_o
   );

   modport slave (
      input  op_i, funct_i, imem_ack_i, zero_i,
      output imem_req_o, ir_we_o, pc_we_o, pc_src_o, alu_src_a_o, alu_src_b_o,
             alu_ctrl_o, reg_we_o, reg_dst_o, illegal_o, state_o
   );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational instruction decoder: op/funct to instruction class, ALU controls
// and a legality flag.
module ctrl_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec = '{cls: CLS_ILLEGAL, alu_ctrl: ALU_ADD, alu_src_a: 1'b0,
              alu_src_b: SRCB_RT, legal: 1'b0};
      case (op)
         OP_RTYPE: begin
            dec.cls   = CLS_RTYPE;
            dec.legal = 1'b1;
            case (funct)
               FN_ADD:  dec.alu_ctrl = ALU_ADD;
               FN_SUB:  dec.alu_ctrl = ALU_SUB;
               FN_AND:  dec.alu_ctrl = ALU_AND;
               FN_OR:   dec.alu_ctrl = ALU_OR;
               FN_SLT:  dec.alu_ctrl = ALU_SLT;
               FN_SLLV: dec.alu_ctrl = ALU_SLL;
               FN_SRLV: dec.alu_ctrl = ALU_SRL;
               // Immediate shifts take operand A from the shamt field.
               FN_SLL: begin
                  dec.alu_ctrl  = ALU_SLL;
                  dec.alu_src_a = 1'b1;
               end
               FN_SRL: begin
                  dec.alu_ctrl  = ALU_SRL;
                  dec.alu_src_a = 1'b1;
               end
               default: begin
                  dec.cls   = CLS_ILLEGAL;
                  dec.legal = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin
            dec.cls       = CLS_IMM;
            dec.alu_src_b = SRCB_SEXT;
            dec.legal     = 1'b1;
         end
         OP_ORI: begin
            dec.cls       = CLS_IMM;
            dec.alu_ctrl  = ALU_OR;
            dec.alu_src_b = SRCB_ZEXT;
            dec.legal     = 1'b1;
         end
         OP_BEQ: begin
            dec.cls      = CLS_BEQ;
            dec.alu_ctrl = ALU_SUB;
            dec.legal    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/WB/BRANCH/ERR with an
// instruction-memory wait timeout and decode fields latched in DECODE.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int IMEM_TIMEOUT = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   multicycle_ctrl_if.slave bus
);

   localparam int CW = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_TIMEOUT - 1);

   state_e        state, state_nx;
   logic [CW-1:0] wait_cnt;
   logic [3:0]    lat_alu_ctrl;
   logic          lat_src_a;
   logic [1:0]    lat_src_b;
   logic          lat_rtype;
   dec_t          dec;

   ctrl_decoder u_dec (
      .op    (bus.op_i),
      .funct (bus.funct_i),
      .dec   (dec)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= ST_FETCH;
         wait_cnt     <= '0;
         lat_alu_ctrl <= ALU_ADD;
         lat_src_a    <= 1'b0;
         lat_src_b    <= SRCB_RT;
         lat_rtype    <= 1'b1;
      end else begin
         state <= state_nx;
         if (state == ST_FETCH && !bus.imem_ack_i && wait_cnt != CNT_LAST)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         // EXEC and WB work from this snapshot, not from the live op/funct.
         if (state == ST_DECODE) begin
            lat_alu_ctrl <= dec.alu_ctrl;
            lat_src_a    <= dec.alu_src_a;
            lat_src_b    <= dec.alu_src_b;
            lat_rtype    <= (dec.cls == CLS_RTYPE);
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_FETCH: begin
            if (bus.imem_ack_i)          state_nx = ST_DECODE;
            else if (wait_cnt == CNT_LAST) state_nx = ST_ERR;
         end
         ST_DECODE: begin
            if (!dec.legal)              state_nx = ST_ERR;
            else if (dec.cls == CLS_BEQ) state_nx = ST_BRANCH;
            else                         state_nx = ST_EXEC;
         end
         ST_EXEC:   state_nx = ST_WB;
         ST_WB:     state_nx = ST_FETCH;
         ST_BRANCH: state_nx = ST_FETCH;
         ST_ERR:    state_nx = ST_ERR;
         default:   state_nx = ST_ERR;
      endcase
   end

   // Outputs are forced low for as long as reset is held, not just until the next edge.
   always_comb begin
      bus.imem_req_o  = 1'b0;
      bus.ir_we_o     = 1'b0;
      bus.pc_we_o     = 1'b0;
      bus.pc_src_o    = 1'b0;
      bus.alu_src_a_o = 1'b0;
      bus.alu_src_b_o = SRCB_RT;
      bus.alu_ctrl_o  = 4'b0000;
      bus.reg_we_o    = 1'b0;
      bus.reg_dst_o   = 1'b0;
      bus.illegal_o   = 1'b0;
      if (rst_i) begin
         case (state)
            ST_FETCH: begin
               bus.imem_req_o = 1'b1;
               bus.ir_we_o    = bus.imem_ack_i;
               bus.pc_we_o    = bus.imem_ack_i;
            end
            ST_EXEC: begin
               bus.alu_ctrl_o  = lat_alu_ctrl;
               bus.alu_src_a_o = lat_src_a;
               bus.alu_src_b_o = lat_src_b;
            end
            ST_WB: begin
               bus.alu_ctrl_o  = lat_alu_ctrl;
               bus.alu_src_a_o = lat_src_a;
               bus.alu_src_b_o = lat_src_b;
               bus.reg_we_o    = 1'b1;
               bus.reg_dst_o   = lat_rtype;
            end
            ST_BRANCH: begin
               bus.alu_ctrl_o = ALU_SUB;
               bus.pc_we_o    = bus.zero_i;
               bus.pc_src_o   = 1'b1;
            end
            ST_ERR:  bus.illegal_o = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl: one record per instruction plus
// hand sequences for reset, fetch timeout and reset during write-back.
module tb_multicycle_ctrl;

   typedef enum {K_ALU, K_BR, K_ERR} kind_e;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      kind_e      kind;
      logic [3:0] alu;
      logic       src_a;
      logic [1:0] src_b;
      logic       reg_dst;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   multicycle_ctrl_if bus();

   multicycle_ctrl #(.IMEM_TIMEOUT(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int   n_pass  = 0;
   int   n_total = 0;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic vec_t mk(input string name, input logic [5:0] op, input logic [5:0] funct,
                               input logic zero, input kind_e kind, input logic [3:0] alu,
                               input logic src_a, input logic [1:0] src_b, input logic reg_dst);
      vec_t v;
      v.name = name; v.op = op; v.funct = funct; v.zero = zero; v.kind = kind;
      v.alu = alu; v.src_a = src_a; v.src_b = src_b; v.reg_dst = reg_dst;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Starts one cycle after a rising edge in a fresh FETCH; ends the same way.
   task automatic run_vec(input vec_t v);
      bus.op_i = v.op; bus.funct_i = v.funct; bus.zero_i = v.zero; bus.imem_ack_i = 1'b1;
      @(negedge clk);
      chk({v.name, " fetch state"},  bus.state_o, 0);
      chk({v.name, " fetch req"},    bus.imem_req_o, 1);
      chk({v.name, " fetch ir_we"},  bus.ir_we_o, 1);
      chk({v.name, " fetch pc_we"},  bus.pc_we_o, 1);
      chk({v.name, " fetch pc_src"}, bus.pc_src_o, 0);
      tick();
      @(negedge clk);
      chk({v.name, " decode state"}, bus.state_o, 1);
      chk({v.name, " decode ir_we"}, bus.ir_we_o, 0);
      chk({v.name, " decode pc_we"}, bus.pc_we_o, 0);
      chk({v.name, " decode req"},   bus.imem_req_o, 0);
      tick();
      bus.imem_ack_i = 1'b0;
      @(negedge clk);
      case (v.kind)
         K_ERR: begin
            chk({v.name, " err state"},   bus.state_o, 5);
            chk({v.name, " err illegal"}, bus.illegal_o, 1);
            chk({v.name, " err reg_we"},  bus.reg_we_o, 0);
            chk({v.name, " err req"},     bus.imem_req_o, 0);
            tick();
            @(negedge clk);
            chk({v.name, " err hold"},    bus.state_o, 5);
            chk({v.name, " err reg_we2"}, bus.reg_we_o, 0);
            do_reset();
         end
         K_BR: begin
            chk({v.name, " br state"},  bus.state_o, 4);
            chk({v.name, " br alu"},    bus.alu_ctrl_o, 4'b0110);
            chk({v.name, " br src_b"},  bus.alu_src_b_o, 0);
            chk({v.name, " br pc_we"},  bus.pc_we_o, v.zero);
            chk({v.name, " br pc_src"}, bus.pc_src_o, 1);
            chk({v.name, " br reg_we"}, bus.reg_we_o, 0);
            tick();
         end
         default: begin
            chk({v.name, " exec state"},  bus.state_o, 2);
            chk({v.name, " exec alu"},    bus.alu_ctrl_o, v.alu);
            chk({v.name, " exec src_a"},  bus.alu_src_a_o, v.src_a);
            chk({v.name, " exec src_b"},  bus.alu_src_b_o, v.src_b);
            chk({v.name, " exec reg_we"}, bus.reg_we_o, 0);
            chk({v.name, " exec pc_we"},  bus.pc_we_o, 0);
            tick();
            @(negedge clk);
            chk({v.name, " wb state"},   bus.state_o, 3);
            chk({v.name, " wb reg_we"},  bus.reg_we_o, 1);
            chk({v.name, " wb reg_dst"}, bus.reg_dst_o, v.reg_dst);
            chk({v.name, " wb alu"},     bus.alu_ctrl_o, v.alu);
            chk({v.name, " wb src_a"},   bus.alu_src_a_o, v.src_a);
            chk({v.name, " wb src_b"},   bus.alu_src_b_o, v.src_b);
            chk({v.name, " wb pc_we"},   bus.pc_we_o, 0);
            tick();
         end
      endcase
   endtask

   initial begin
      //                name      op         funct      z     kind   alu      a     b     dst
      vecs.push_back(mk("addi",  6'b001000, 6'b000000, 1'b0, K_ALU, 4'b0010, 1'b0, 2'd1, 1'b0));
      vecs.push_back(mk("ori",   6'b001101, 6'b111111, 1'b0, K_ALU, 4'b0001, 1'b0, 2'd2, 1'b0));
      vecs.push_back(mk("add",   6'b000000, 6'b100000, 1'b0, K_ALU, 4'b0010, 1'b0, 2'd0, 1'b1));
      vecs.push_back(mk("sub",   6'b000000, 6'b100010, 1'b0, K_ALU, 4'b0110, 1'b0, 2'd0, 1'b1));
      vecs.push_back(mk("and",   6'b000000, 6'b100100, 1'b0, K_ALU, 4'b0000, 1'b0, 2'd0, 1'b1));
      vecs.push_back(mk("or",    6'b000000, 6'b100101, 1'b0, K_ALU, 4'b0001, 1'b0, 2'd0, 1'b1));
      vecs.push_back(mk("slt",   6'b000000, 6'b101010, 1'b0, K_ALU, 4'b0111, 1'b0, 2'd0, 1'b1));
      vecs.push_back(mk("sll",   6'b000000, 6'b000000, 1'b0, K_ALU, 4'b1000, 1'b1, 2'd0, 1'b1));
      vecs.push_back(mk("srlv",  6'b000000, 6'b000110, 1'b0, K_ALU, 4'b1001, 1'b0, 2'd0, 1'b1));
      vecs.push_back(mk("sllv",  6'b000000, 6'b000100, 1'b0, K_ALU, 4'b1000, 1'b0, 2'd0, 1'b1));
      vecs.push_back(mk("srl",   6'b000000, 6'b000010, 1'b0, K_ALU, 4'b1001, 1'b1, 2'd0, 1'b1));
      vecs.push_back(mk("beq_t", 6'b000100, 6'b000000, 1'b1, K_BR,  4'b0110, 1'b0, 2'd0, 1'b0));
      vecs.push_back(mk("beq_n", 6'b000100, 6'b000000, 1'b0, K_BR,  4'b0110, 1'b0, 2'd0, 1'b0));
      vecs.push_back(mk("lw",    6'b100011, 6'b000000, 1'b0, K_ERR, 4'b0000, 1'b0, 2'd0, 1'b0));
      vecs.push_back(mk("badfn", 6'b000000, 6'b000001, 1'b0, K_ERR, 4'b0000, 1'b0, 2'd0, 1'b0));
      vecs.push_back(mk("j",     6'b000010, 6'b000000, 1'b0, K_ERR, 4'b0000, 1'b0, 2'd0, 1'b0));

      // Reset held: everything low even with ack high.
      bus.op_i = 6'b000000; bus.funct_i = 6'b000000; bus.zero_i = 1'b1; bus.imem_ack_i = 1'b1;
      #2;
      chk("rst state",   bus.state_o, 0);
      chk("rst req",     bus.imem_req_o, 0);
      chk("rst ir_we",   bus.ir_we_o, 0);
      chk("rst pc_we",   bus.pc_we_o, 0);
      chk("rst reg_we",  bus.reg_we_o, 0);
      chk("rst illegal", bus.illegal_o, 0);
      tick();
      do_reset();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Ack withheld 7 cycles, given on the 8th: still reaches DECODE.
      bus.imem_ack_i = 1'b0; bus.op_i = 6'b000100; bus.zero_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("wait7 state", bus.state_o, 0);
         chk("wait7 req",   bus.imem_req_o, 1);
         tick();
      end
      bus.imem_ack_i = 1'b1;
      @(negedge clk);
      chk("wait7 ir_we", bus.ir_we_o, 1);
      tick();
      bus.imem_ack_i = 1'b0;
      @(negedge clk);
      chk("wait7 decode", bus.state_o, 1);
      tick();
      tick();

      // Ack withheld 8 cycles: ERR, sticky until reset.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("wait8 state", bus.state_o, 0);
         tick();
      end
      @(negedge clk);
      chk("timeout state",   bus.state_o, 5);
      chk("timeout illegal", bus.illegal_o, 1);
      chk("timeout req",     bus.imem_req_o, 0);
      bus.imem_ack_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("timeout hold state", bus.state_o, 5);
         chk("timeout hold req",   bus.imem_req_o, 0);
         chk("timeout hold ir_we", bus.ir_we_o, 0);
         chk("timeout hold ill",   bus.illegal_o, 1);
      end
      tick();
      do_reset();

      // ori interrupted by reset in WB.
      bus.op_i = 6'b001101; bus.imem_ack_i = 1'b1;
      @(negedge clk);
      chk("ori2 illegal cleared", bus.illegal_o, 0);
      chk("ori2 fetch state",     bus.state_o, 0);
      tick();
      bus.imem_ack_i = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("ori2 wb state",  bus.state_o, 3);
      chk("ori2 wb reg_we", bus.reg_we_o, 1);
      #1 rst = 1'b0;
      #1;
      chk("ori2 rst reg_we", bus.reg_we_o, 0);
      chk("ori2 rst state",  bus.state_o, 0);
      chk("ori2 rst pc_we",  bus.pc_we_o, 0);
      tick();
      @(negedge clk);
      chk("ori2 hold reg_we", bus.reg_we_o, 0);
      chk("ori2 hold pc_we",  bus.pc_we_o, 0);
      chk("ori2 hold req",    bus.imem_req_o, 0);
      #1 rst = 1'b1;
      #1;
      chk("ori2 release state", bus.state_o, 0);
      chk("ori2 release req",   bus.imem_req_o, 1);
      chk("ori2 release ir_we", bus.ir_we_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
